// File: rtl/aes_pkg.sv
// Shared AES definitions: the 128-bit state type and byte count used by the
// round-step blocks.
package aes_pkg;

    localparam int AES_STATE_BYTES = 16;
    localparam int AES_STATE_BITS  = 8 * AES_STATE_BYTES;

    // Byte i of the state lives in bits [8i+7:8i].
    typedef logic [AES_STATE_BITS-1:0] aes_state_t;

endpackage

// File: rtl/inv_s_box.sv
// AES inverse S-box: purely combinational 8-bit table lookup.
// Port order (out, in) matches the forward s_box.
module inv_s_box (
    output logic [7:0] out,
    input  logic [7:0] in
);

    localparam logic [7:0] INV_SBOX [256] = '{
        8'h52, 8'h09, 8'h6a, 8'hd5, 8'h30, 8'h36, 8'ha5, 8'h38, 8'hbf, 8'h40, 8'ha3, 8'h9e, 8'h81, 8'hf3, 8'hd7, 8'hfb,
        8'h7c, 8'he3, 8'h39, 8'h82, 8'h9b, 8'h2f, 8'hff, 8'h87, 8'h34, 8'h8e, 8'h43, 8'h44, 8'hc4, 8'hde, 8'he9, 8'hcb,
        8'h54, 8'h7b, 8'h94, 8'h32, 8'ha6, 8'hc2, 8'h23, 8'h3d, 8'hee, 8'h4c, 8'h95, 8'h0b, 8'h42, 8'hfa, 8'hc3, 8'h4e,
        8'h08, 8'h2e, 8'ha1, 8'h66, 8'h28, 8'hd9, 8'h24, 8'hb2, 8'h76, 8'h5b, 8'ha2, 8'h49, 8'h6d, 8'h8b, 8'hd1, 8'h25,
        8'h72, 8'hf8, 8'hf6, 8'h64, 8'h86, 8'h68, 8'h98, 8'h16, 8'hd4, 8'ha4, 8'h5c, 8'hcc, 8'h5d, 8'h65, 8'hb6, 8'h92,
        8'h6c, 8'h70, 8'h48, 8'h50, 8'hfd, 8'hed, 8'hb9, 8'hda, 8'h5e, 8'h15, 8'h46, 8'h57, 8'ha7, 8'h8d, 8'h9d, 8'h84,
        8'h90, 8'hd8, 8'hab, 8'h00, 8'h8c, 8'hbc, 8'hd3, 8'h0a, 8'hf7, 8'he4, 8'h58, 8'h05, 8'hb8, 8'hb3, 8'h45, 8'h06,
        8'hd0, 8'h2c, 8'h1e, 8'h8f, 8'hca, 8'h3f, 8'h0f, 8'h02, 8'hc1, 8'haf, 8'hbd, 8'h03, 8'h01, 8'h13, 8'h8a, 8'h6b,
        8'h3a, 8'h91, 8'h11, 8'h41, 8'h4f, 8'h67, 8'hdc, 8'hea, 8'h97, 8'hf2, 8'hcf, 8'hce, 8'hf0, 8'hb4, 8'he6, 8'h73,
        8'h96, 8'hac, 8'h74, 8'h22, 8'he7, 8'had, 8'h35, 8'h85, 8'he2, 8'hf9, 8'h37, 8'he8, 8'h1c, 8'h75, 8'hdf, 8'h6e,
        8'h47, 8'hf1, 8'h1a, 8'h71, 8'h1d, 8'h29, 8'hc5, 8'h89, 8'h6f, 8'hb7, 8'h62, 8'h0e, 8'haa, 8'h18, 8'hbe, 8'h1b,
        8'hfc, 8'h56, 8'h3e, 8'h4b, 8'hc6, 8'hd2, 8'h79, 8'h20, 8'h9a, 8'hdb, 8'hc0, 8'hfe, 8'h78, 8'hcd, 8'h5a, 8'hf4,
        8'h1f, 8'hdd, 8'ha8, 8'h33, 8'h88, 8'h07, 8'hc7, 8'h31, 8'hb1, 8'h12, 8'h10, 8'h59, 8'h27, 8'h80, 8'hec, 8'h5f,
        8'h60, 8'h51, 8'h7f, 8'ha9, 8'h19, 8'hb5, 8'h4a, 8'h0d, 8'h2d, 8'he5, 8'h7a, 8'h9f, 8'h93, 8'hc9, 8'h9c, 8'hef,
        8'ha0, 8'he0, 8'h3b, 8'h4d, 8'hae, 8'h2a, 8'hf5, 8'hb0, 8'hc8, 8'heb, 8'hbb, 8'h3c, 8'h83, 8'h53, 8'h99, 8'h61,
        8'h17, 8'h2b, 8'h04, 8'h7e, 8'hba, 8'h77, 8'hd6, 8'h26, 8'he1, 8'h69, 8'h14, 8'h63, 8'h55, 8'h21, 8'h0c, 8'h7d
    };

    assign out = INV_SBOX[in];

endmodule

// File: rtl/inv_sub_bytes_seq.sv
// Sequential AES InvSubBytes: processes a 128-bit state BYTES_PER_CYCLE bytes
// per cycle through a small bank of inverse S-boxes, lowest chunk first.
module inv_sub_bytes_seq
    import aes_pkg::*;
#(
    parameter int BYTES_PER_CYCLE = 4
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [127:0] in_data,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [127:0] out_data
);

    localparam int NUM_CHUNKS = AES_STATE_BYTES / BYTES_PER_CYCLE;
    localparam int CHUNK_W    = 8 * BYTES_PER_CYCLE;
    localparam int CNT_W      = (NUM_CHUNKS > 1) ? $clog2(NUM_CHUNKS) : 1;
    localparam logic [CNT_W-1:0] LAST_CHUNK = CNT_W'(NUM_CHUNKS - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           state;
    state_t           state_nxt;
    aes_state_t       work_q;
    logic [CNT_W-1:0] cnt_q;
    logic [CHUNK_W-1:0] chunk_in;
    logic [CHUNK_W-1:0] chunk_out;

    // Handshake: a transfer happens on a rising edge where valid and ready are
    // both 1; the producer holds data stable while valid=1 and ready=0.
    assign in_ready  = (state == IDLE);
    assign out_valid = (state == DONE);
    assign out_data  = work_q;

    always_comb begin
        chunk_in = '0;
        for (int c = 0; c < NUM_CHUNKS; c++) begin
            if (cnt_q == CNT_W'(c)) begin
                chunk_in = work_q[c*CHUNK_W +: CHUNK_W];
            end
        end
    end

    for (genvar g = 0; g < BYTES_PER_CYCLE; g++) begin : g_box
        inv_s_box u_inv_s_box (
            .out (chunk_out[8*g +: 8]),
            .in  (chunk_in[8*g +: 8])
        );
    end

    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE:    if (in_valid)            state_nxt = BUSY;
            BUSY:    if (cnt_q == LAST_CHUNK) state_nxt = DONE;
            DONE:    if (out_ready)           state_nxt = IDLE;
            default:                          state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= IDLE;
            cnt_q  <= '0;
            work_q <= '0;
        end else begin
            state <= state_nxt;
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        work_q <= in_data;
                        cnt_q  <= '0;
                    end
                end
                BUSY: begin
                    for (int c = 0; c < NUM_CHUNKS; c++) begin
                        if (cnt_q == CNT_W'(c)) begin
                            work_q[c*CHUNK_W +: CHUNK_W] <= chunk_out;
                        end
                    end
                    // Counter parks on the last chunk; it is cleared on the next load.
                    if (cnt_q != LAST_CHUNK) begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_inv_sub_bytes_seq.sv
// Bench for inv_sub_bytes_seq: one instance per legal BYTES_PER_CYCLE, table
// vectors on B=4, hold/reset/stream sequences, and a forward-S-box round trip.
module tb_inv_sub_bytes_seq;

    localparam int NB = 5;
    localparam int W  = 128;
    localparam int BPC [NB] = '{1, 2, 4, 8, 16};
    localparam int K4  = 2;
    localparam int K16 = 4;

    logic         clk;
    logic         rst_n;
    logic         in_valid  [NB];
    logic         in_ready  [NB];
    logic [127:0] in_data   [NB];
    logic         out_valid [NB];
    logic         out_ready [NB];
    logic [127:0] out_data  [NB];

    for (genvar g = 0; g < NB; g++) begin : g_dut
        inv_sub_bytes_seq #(.BYTES_PER_CYCLE(BPC[g])) u_dut (
            .clk       (clk),
            .rst_n     (rst_n),
            .in_valid  (in_valid[g]),
            .in_ready  (in_ready[g]),
            .in_data   (in_data[g]),
            .out_valid (out_valid[g]),
            .out_ready (out_ready[g]),
            .out_data  (out_data[g])
        );
    end

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic [127:0] din;
        logic [127:0] dout;
    } vec_t;

    vec_t          tv [6];
    logic [7:0]    sbox_t [256];
    logic [W-1:0]  exp_q [$];
    int            n_vec;
    int            n_err;

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Forward S-box built from GF(2^8) inversion plus the affine map.
    function automatic logic [7:0] gmul(input logic [7:0] a_in, input logic [7:0] b_in);
        logic [7:0] a, b, p;
        a = a_in; b = b_in; p = 8'h00;
        for (int i = 0; i < 8; i++) begin
            if (b[0]) p = p ^ a;
            a = {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
            b = b >> 1;
        end
        return p;
    endfunction

    function automatic logic [7:0] fwd_sbox(input logic [7:0] x);
        logic [7:0] inv, s;
        inv = 8'h01;
        for (int i = 0; i < 254; i++) inv = gmul(inv, x);
        s = inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]} ^ {inv[4:0], inv[7:5]} ^ {inv[3:0], inv[7:4]};
        return s ^ 8'h63;
    endfunction

    // driver: present d on instance k, return edges from accept edge (counted as 1) to out_valid
    task automatic send(input int k, input logic [127:0] d, output int lat);
        int cyc;
        cyc = 0;
        in_valid[k] = 1'b1;
        in_data[k]  = d;
        while (!in_ready[k] && cyc < 100) begin
            @(posedge clk); #1;
            cyc++;
        end
        check("accept_ready", 128'(in_ready[k]), 128'(1));
        @(posedge clk); #1;
        in_valid[k] = 1'b0;
        lat = 1;
        while (!out_valid[k] && lat < 100) begin
            @(posedge clk); #1;
            lat++;
        end
    endtask

    task automatic round_trip(input int k, input int n);
        logic [127:0] x, y;
        int lat;
        for (int i = 0; i < n; i++) begin
            x = {$urandom(), $urandom(), $urandom(), $urandom()};
            for (int b = 0; b < 16; b++) y[8*b +: 8] = sbox_t[x[8*b +: 8]];
            send(k, y, lat);
            check("rt_latency", 128'(lat), 128'(16 / BPC[k] + 1));
            check("rt_data", out_data[k], x);
        end
    endtask

    initial begin
        int lat;
        int n_res;
        int last;
        int vi;
        logic acc;
        logic [127:0] hold_exp;

        n_vec = 0;
        n_err = 0;
        for (int i = 0; i < 256; i++) sbox_t[i] = fwd_sbox(8'(i));

        tv[0] = '{din: {16{8'h63}},            dout: 128'h0};
        tv[1] = '{din: {4{32'h00ed7c16}},      dout: {4{32'h525301ff}}};
        tv[2] = '{din: 128'h0,                 dout: {16{8'h52}}};
        tv[3] = '{din: {16{8'hff}},            dout: {16{8'h7d}}};
        tv[4] = '{din: 128'h0f0e0d0c0b0a09080706050403020100,
                  dout: 128'hfbd7f3819ea340bf38a53630d56a0952};
        tv[5] = '{din: {4{32'h011080f0}},      dout: {4{32'h097c3a17}}};

        rst_n = 1'b0;
        for (int k = 0; k < NB; k++) begin
            in_valid[k]  = 1'b0;
            in_data[k]   = '0;
            out_ready[k] = 1'b1;
        end
        #2;
        for (int k = 0; k < NB; k++) begin
            check("reset_in_ready",  128'(in_ready[k]),  128'(1));
            check("reset_out_valid", 128'(out_valid[k]), 128'(0));
            check("reset_out_data",  out_data[k],        128'h0);
        end
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;

        // table vectors on B=4
        for (int i = 0; i < 6; i++) begin
            send(K4, tv[i].din, lat);
            check("tbl_latency", 128'(lat), 128'(5));
            check("tbl_data", out_data[K4], tv[i].dout);
        end

        // B=16 single-transfer latency
        send(K16, tv[1].din, lat);
        check("b16_latency", 128'(lat), 128'(2));
        check("b16_data", out_data[K16], tv[1].dout);

        // backpressure: DONE held for 10 cycles, in_valid pulses ignored
        out_ready[K4] = 1'b0;
        send(K4, tv[5].din, lat);
        check("hold_latency", 128'(lat), 128'(5));
        hold_exp = tv[5].dout;
        for (int i = 0; i < 10; i++) begin
            in_valid[K4] = 1'(i % 2);
            in_data[K4]  = {$urandom(), $urandom(), $urandom(), $urandom()};
            @(posedge clk); #1;
            check("hold_out_valid", 128'(out_valid[K4]), 128'(1));
            check("hold_out_data",  out_data[K4],        hold_exp);
            check("hold_in_ready",  128'(in_ready[K4]),  128'(0));
        end
        in_valid[K4]  = 1'b1;
        out_ready[K4] = 1'b1;
        @(posedge clk); #1;
        check("release_out_valid", 128'(out_valid[K4]), 128'(0));
        check("release_no_accept", 128'(in_ready[K4]),  128'(1));
        in_valid[K4] = 1'b0;
        @(posedge clk); #1;

        // reset during BUSY cycle 2 discards the partial result
        in_valid[K4] = 1'b1;
        in_data[K4]  = tv[3].din;
        @(posedge clk); #1;
        in_valid[K4] = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b0;
        #1;
        check("rst_out_valid", 128'(out_valid[K4]), 128'(0));
        check("rst_in_ready",  128'(in_ready[K4]),  128'(1));
        check("rst_out_data",  out_data[K4],        128'h0);
        repeat (2) begin
            @(posedge clk); #1;
            check("rst_no_pulse", 128'(out_valid[K4]), 128'(0));
        end
        @(negedge clk);
        rst_n = 1'b1;
        send(K4, tv[1].din, lat);
        check("post_rst_latency", 128'(lat), 128'(5));
        check("post_rst_data", out_data[K4], tv[1].dout);
        @(posedge clk); #1;

        // B=16 back-to-back stream: one result every 3 cycles
        exp_q.delete();
        n_res = 0;
        last  = -1;
        vi    = 0;
        in_valid[K16] = 1'b1;
        in_data[K16]  = tv[0].din;
        for (int cyc = 0; cyc < 40 && n_res < 4; cyc++) begin
            acc = in_valid[K16] && in_ready[K16];
            @(posedge clk); #1;
            if (acc) begin
                exp_q.push_back(tv[vi].dout);
                vi++;
                if (vi < 4) in_data[K16] = tv[vi].din;
                else        in_valid[K16] = 1'b0;
            end
            if (out_valid[K16]) begin
                if (exp_q.size() == 0) check("stream_unexpected", out_data[K16], 128'hx);
                else                   check("stream_data", out_data[K16], exp_q.pop_front());
                if (last >= 0) check("stream_gap", 128'(cyc - last), 128'(3));
                last = cyc;
                n_res++;
            end
        end
        check("stream_count", 128'(n_res), 128'(4));
        in_valid[K16] = 1'b0;
        @(posedge clk); #1;

        // round trip through the forward S-box on every legal width
        fork
            round_trip(0, 1000);
            round_trip(1, 1000);
            round_trip(2, 1000);
            round_trip(3, 1000);
            round_trip(4, 1000);
        join

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/inv_sub_bytes_seq.md
INV_SUB_BYTES_SEQ -- requirements
Module: inv_sub_bytes_seq

Interface
REQ-001 SHALL provide parameter: BYTES_PER_CYCLE, 4, inverse S-box lookups per busy cycle; legal values 1, 2, 4, 8, 16.
REQ-002 SHALL provide port: clk  input  1  single clock; all state updates on rising edge.
REQ-003 SHALL provide port: rst_n  input  1  reset; asynchronous, active-low.
REQ-004 SHALL provide port: in_valid  input  1  in_data holds a valid 128-bit state.
REQ-005 SHALL provide port: in_ready  output  1  block can accept a state.
REQ-006 SHALL provide port: in_data  input  128  ciphertext-side state; byte i = bits [8i+7:8i].
REQ-007 SHALL provide port: out_valid  output  1  out_data holds a finished result.
REQ-008 SHALL provide port: out_ready  input  1  downstream accepts out_data.
REQ-009 SHALL provide port: out_data  output  128  InvSubBytes(in_data); byte i = InvSbox(in byte i).

Function
REQ-010 SHALL implement the three-state FSM IDLE, BUSY and DONE.
REQ-011 SHALL drive in_ready = 1 in IDLE only and out_valid = 1 in DONE only.
REQ-012 SHALL, in IDLE with in_valid=1, load in_data into a 128-bit working register, clear chunk counter, and enter BUSY next edge.
REQ-013 SHALL, in BUSY, replace chunk c (bytes c*B .. c*B+B-1, B=BYTES_PER_CYCLE) of the working register with its inverse S-box values each cycle, lowest chunk first, then increment c.
REQ-014 SHALL enter DONE on the edge that writes the last chunk (c = 16/B-1), giving exactly 16/B BUSY cycles; out_valid rises 16/B+1 edges after the accepting edge.
REQ-015 SHALL drive out_data from the working register and hold it stable while out_valid=1 and out_ready=0.
REQ-016 SHALL, in DONE with out_ready=1, return to IDLE next edge; no new acceptance in that same cycle.
REQ-017 SHALL ignore in_valid and in_data outside IDLE; out_ready outside DONE has no effect.
REQ-018 SHALL size the chunk counter to $clog2(16/B) bits, minimum 1 bit; it must not wrap inside BUSY.
REQ-019 SHALL be byte-wise exact: no carries or cross-byte interaction.

Reset
REQ-020 SHALL, while rst_n=0, force FSM=IDLE, counter=0, working register=0, out_valid=0, in_ready=1, out_data=0.
REQ-021 SHALL, on reset assertion mid-BUSY or mid-DONE, discard the partial or unconsumed result with no output pulse.
REQ-022 SHALL accept a new state on the first rising edge after rst_n deasserts if in_valid=1.

Structure
REQ-023 SHALL take AES_STATE_BYTES=16 and the 128-bit state typedef from shared package aes_pkg; the FSM state enum is local.
REQ-024 SHALL instantiate BYTES_PER_CYCLE copies of the purely combinational sub-module inv_s_box (8-bit in, 8-bit out, 256-entry table), using the existing s_box port order (out, in).

Verification
REQ-025 SHALL verify: in_data = 16 x 0x63, B=4 -> out_valid after 5 edges, out_data = 128'h0.
REQ-026 SHALL verify: bytes {0x16,0x7c,0xed,0x00} repeated -> corresponding out bytes {0xff,0x01,0x53,0x52}.
REQ-027 SHALL verify: round-trip, random 128-bit X through subByte then this block -> out_data = X, 1000 vectors, all legal B.
REQ-028 SHALL verify: out_ready held 0 for 10 cycles in DONE -> out_data/out_valid stable, in_ready=0, in_valid pulses ignored.
REQ-029 SHALL verify: rst_n dropped on BUSY cycle 2 -> out_valid=0, in_ready=1 immediately; next accepted state processes correctly.
REQ-030 SHALL verify: B=16 -> out_valid 2 edges after acceptance; back-to-back stream with out_ready=1 gives one result per 3 cycles.
